tdm_demux: RTL and testbench

Time-division demultiplexer: the receiving end of the team's 1-bit mux/TDM link. It accepts a serial stream of slot samples with a frame-sync marker and routes each sample round-robin to one of LANES output lanes. It assembles each full frame in a staging register and presents it in parallel with a one-cycle valid strobe. It sits downstream of the MUX2_1-style serializer in the link datapath and also tracks frame alignment.

---
 rtl/tdm_demux_pkg.sv | 18 +
 rtl/tdm_slot_counter.sv | 30 +++
 rtl/tdm_demux.sv | 118 +++++++++++
 tb/tb_tdm_demux.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux_pkg.sv
// tdm_demux_pkg: shared types and sizing for the TDM demultiplexer.
// DEMUX_PARITY_EN adds one parity slot to every frame.
package tdm_demux_pkg;
    typedef enum logic {HUNT, LOCKED} state_e;
    localparam int DEF_LANES = 4;
    localparam int DEF_WIDTH = 1;
`ifdef DEMUX_PARITY_EN
    localparam int PARITY_SLOTS = 1;
`else
    localparam int PARITY_SLOTS = 0;
`endif
    function automatic int slot_count(int lanes);
        return lanes + PARITY_SLOTS;
    endfunction
    function automatic int slot_width(int lanes);
        return $clog2(lanes + 1);
    endfunction
endpackage

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: wrap-around slot index with load-zero/load-one/increment
// controls and a terminal-slot flag.
module tdm_slot_counter #(
    parameter int NSLOT = 4,
    parameter int SW    = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ld_zero_i,
    input  logic          ld_one_i,
    input  logic          inc_i,
    output logic [SW-1:0] slot_o,
    output logic          last_o
);
    logic [SW-1:0] slot_q, slot_d;

    assign last_o = slot_q == SW'(NSLOT - 1);
    assign slot_o = slot_q;

    always_comb begin
        slot_d = ld_zero_i ? '0 :
                 ld_one_i  ? SW'(1) :
                 inc_i     ? (last_o ? '0 : slot_q + SW'(1)) : slot_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) slot_q <= '0;
        else       slot_q <= slot_d;
    end
endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: serial TDM slot stream to parallel lanes with frame alignment.
// Optional DEMUX_PARITY_EN: trailing parity slot checked before dout updates.
module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic [WIDTH-1:0]           din,
    input  logic                       din_vld,
    input  logic                       frame_sync,
    output logic [LANES*WIDTH-1:0]     dout,
    output logic                       dout_vld,
    output logic                       locked,
    output logic [$clog2(LANES+1)-1:0] slot,
    output logic                       sync_err,
    output logic                       par_err
);
    localparam int NSLOT = slot_count(LANES);
    localparam int SW    = slot_width(LANES);

    state_e                 state_q, state_d;
    logic [LANES*WIDTH-1:0] stg_q, stg_d, dout_q, dout_d, frame, start;
    logic                   vld_q, vld_d, serr_q, serr_d, perr_q, perr_d;
    logic                   ld_zero, ld_one, inc, last;
    logic [SW-1:0]          slot_q;

    tdm_slot_counter #(.NSLOT(NSLOT), .SW(SW)) u_cnt (
        .clk_i     (sys_clk),
        .rst_i     (sys_rst),
        .ld_zero_i (ld_zero),
        .ld_one_i  (ld_one),
        .inc_i     (inc),
        .slot_o    (slot_q),
        .last_o    (last)
    );

    // staging with the incoming sample merged at the current slot
    always_comb begin
        frame = stg_q;
        for (int k = 0; k < LANES; k++)
            if (SW'(k) == slot_q) frame[k*WIDTH +: WIDTH] = din;
    end

    assign start = {stg_q[LANES*WIDTH-1:WIDTH], din};

`ifdef DEMUX_PARITY_EN
    logic [WIDTH-1:0] par;
    always_comb begin
        par = '0;
        for (int k = 0; k < LANES; k++) par = par ^ stg_q[k*WIDTH +: WIDTH];
    end
`endif

    always_comb begin
        state_d = state_q;
        stg_d   = stg_q;
        dout_d  = dout_q;
        vld_d   = 1'b0;
        serr_d  = 1'b0;
        perr_d  = 1'b0;
        ld_zero = 1'b0;
        ld_one  = 1'b0;
        inc     = 1'b0;
        if (din_vld) begin
            if (frame_sync) begin
                stg_d   = start;
                ld_one  = 1'b1;
                serr_d  = state_q == LOCKED && slot_q != '0;
                state_d = LOCKED;
            end else if (state_q == LOCKED && slot_q == '0) begin
                serr_d  = 1'b1;
                ld_zero = 1'b1;
                state_d = HUNT;
            end else if (state_q == LOCKED) begin
                stg_d = frame;
                inc   = 1'b1;
                if (last) begin
`ifdef DEMUX_PARITY_EN
                    vld_d  = par == din;
                    perr_d = par != din;
                    dout_d = par == din ? stg_q : dout_q;
`else
                    vld_d  = 1'b1;
                    dout_d = frame;
`endif
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= HUNT;
            stg_q   <= '0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
            serr_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stg_q   <= stg_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            serr_q  <= serr_d;
            perr_q  <= perr_d;
        end
    end

    assign dout     = dout_q;
    assign dout_vld = vld_q;
    assign locked   = state_q == LOCKED;
    assign slot     = slot_q;
    assign sync_err = serr_q;
    assign par_err  = perr_q;
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: scoreboard bench for tdm_demux (LANES=4, WIDTH=1), directed
// scenarios followed by randomized traffic; honours DEMUX_PARITY_EN.
module tb_tdm_demux;
    localparam int LANES = 4;
    localparam int WIDTH = 1;
    localparam int SW    = $clog2(LANES + 1);
`ifdef DEMUX_PARITY_EN
    localparam int NSLOT = LANES + 1;
`else
    localparam int NSLOT = LANES;
`endif

    logic                   sys_clk = 0, sys_rst = 1;
    logic [WIDTH-1:0]       din = '0;
    logic                   din_vld = 0, frame_sync = 0;
    logic [LANES*WIDTH-1:0] dout;
    logic                   dout_vld, locked, sync_err, par_err;
    logic [SW-1:0]          slot;

    tdm_demux #(.LANES(LANES), .WIDTH(WIDTH)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .din(din), .din_vld(din_vld),
        .frame_sync(frame_sync), .dout(dout), .dout_vld(dout_vld),
        .locked(locked), .slot(slot), .sync_err(sync_err), .par_err(par_err)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic                   lock;
        logic [SW-1:0]          slot;
        logic [LANES*WIDTH-1:0] dout;
    } exp_t;
    typedef struct {
        int                     stamp;
        logic [LANES*WIDTH-1:0] val;
    } frm_t;

    exp_t exp_tab[int];
    frm_t vq[$];
    int   sq[$], pq[$];
    int   cyc = 0, checks = 0, failures = 0;

    bit                     m_lock;
    int                     m_pos;
    logic [LANES*WIDTH-1:0] m_dout;
    logic [WIDTH-1:0]       m_lane[NSLOT];

    always @(posedge sys_clk) cyc++;

    task automatic chk(string n, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    // reference model: one call per stimulus cycle, outcome stamped to the cycle it must appear in
    task automatic model(bit v, logic [WIDTH-1:0] d, bit fs, int stamp);
        logic [LANES*WIDTH-1:0] f;
        logic [WIDTH-1:0]       p;
        if (v) begin
            if (fs) begin
                if (m_lock && m_pos != 0) sq.push_back(stamp);
                m_lock = 1; m_lane[0] = d; m_pos = 1;
            end else if (m_lock && m_pos == 0) begin
                sq.push_back(stamp);
                m_lock = 0;
            end else if (m_lock) begin
                m_lane[m_pos] = d;
                m_pos++;
                if (m_pos == NSLOT) begin
                    m_pos = 0;
                    p = '0;
                    for (int k = 0; k < LANES; k++) begin
                        f[k*WIDTH +: WIDTH] = m_lane[k];
                        p ^= m_lane[k];
                    end
                    if (NSLOT == LANES || p == m_lane[NSLOT-1]) begin
                        m_dout = f;
                        vq.push_back('{stamp, f});
                    end else pq.push_back(stamp);
                end
            end
        end
        exp_tab[stamp] = '{m_lock, SW'(m_pos), m_dout};
    endtask

    task automatic step(bit v, logic [WIDTH-1:0] d, bit fs);
        din_vld = v; din = d; frame_sync = fs;
        model(v, d, fs, cyc + 1);
        @(posedge sys_clk); #1;
    endtask

    task automatic do_reset();
        sys_rst = 1; din_vld = 0; frame_sync = 0;
        for (int i = 0; i < 2; i++) begin
            m_lock = 0; m_pos = 0; m_dout = '0;
            exp_tab[cyc + 1] = '0;
            @(posedge sys_clk); #1;
        end
        sys_rst = 0;
    endtask

    task automatic send_frame(logic [LANES-1:0] bits, int gap, bit bad_par);
        logic [NSLOT*WIDTH-1:0] s;
        s[LANES-1:0] = bits;
        if (NSLOT > LANES) s[NSLOT-1] = (^bits) ^ bad_par;
        for (int i = 0; i < NSLOT; i++) begin
            if (i > 0) repeat (gap) step(0, WIDTH'($urandom), 1'($urandom));
            step(1, s[i], i == 0);
        end
    endtask

    always @(negedge sys_clk) begin
        if (exp_tab.exists(cyc)) begin
            chk("locked", locked, exp_tab[cyc].lock);
            chk("slot", slot, exp_tab[cyc].slot);
            chk("dout_hold", dout, exp_tab[cyc].dout);
        end
        while (vq.size() > 0 && vq[0].stamp < cyc) begin
            chk("dout_vld_missed", 0, 1); void'(vq.pop_front());
        end
        while (sq.size() > 0 && sq[0] < cyc) begin
            chk("sync_err_missed", 0, 1); void'(sq.pop_front());
        end
        while (pq.size() > 0 && pq[0] < cyc) begin
            chk("par_err_missed", 0, 1); void'(pq.pop_front());
        end
        if (dout_vld) begin
            if (vq.size() == 0 || vq[0].stamp != cyc) chk("dout_vld_unexpected", 1, 0);
            else chk("dout_frame", dout, vq.pop_front().val);
        end
        if (sync_err) begin
            if (sq.size() == 0 || sq[0] != cyc) chk("sync_err_unexpected", 1, 0);
            else chk("sync_err_cycle", sq.pop_front(), cyc);
        end
        if (par_err) begin
            if (pq.size() == 0 || pq[0] != cyc) chk("par_err_unexpected", 1, 0);
            else chk("par_err_cycle", pq.pop_front(), cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        @(posedge sys_clk); #1;
        do_reset();
        chk("rst_outputs", {dout, dout_vld, locked, slot, sync_err, par_err}, 0);
        step(1, 1, 0);
        chk("hunt_no_vld", dout_vld, 0);
        chk("hunt_no_serr", sync_err, 0);
        send_frame(4'b1101, 0, 0);
        chk("clean_dout", dout, 4'b1101);
        chk("clean_vld", dout_vld, 1);
        chk("clean_locked", locked, 1);
        chk("clean_slot", slot, 0);
        step(0, 0, 0);
        chk("vld_one_cycle", dout_vld, 0);
        send_frame(4'b1101, 3, 0);
        chk("gapped_vld", dout_vld, 1);
        chk("gapped_dout", dout, 4'b1101);
        step(1, 1, 1);
        step(1, 0, 0);
        send_frame(4'b1001, 0, 0);
        chk("early_dout", dout, 4'b1001);
        chk("early_locked", locked, 1);
        step(1, 0, 0);
        chk("missing_serr", sync_err, 1);
        chk("missing_locked", locked, 0);
        chk("missing_dout", dout, 4'b1001);
        send_frame(4'b0110, 1, 0);
        chk("relock_dout", dout, 4'b0110);
`ifdef DEMUX_PARITY_EN
        send_frame(4'b1101, 0, 0);
        chk("par_ok_dout", dout, 4'b1101);
        chk("par_ok_vld", dout_vld, 1);
        send_frame(4'b1000, 0, 1);
        chk("par_bad_err", par_err, 1);
        chk("par_bad_dout", dout, 4'b1101);
        chk("par_bad_locked", locked, 1);
`endif
        step(1, 1, 1);
        step(1, 1, 0);
        do_reset();
        chk("midframe_rst", {dout, dout_vld, locked, slot, sync_err, par_err}, 0);
        for (int i = 0; i < 500; i++) begin
            bit v, fs;
            v  = $urandom_range(0, 9) < 7;
            fs = (m_pos == 0) ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 149) == 0) do_reset();
            else step(v, WIDTH'($urandom), fs);
        end
        repeat (3) step(0, 0, 0);
        chk("vld_queue_drained", vq.size(), 0);
        chk("serr_queue_drained", sq.size(), 0);
        chk("perr_queue_drained", pq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
